// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: word-addressed data memory behind a req/ready/rvalid
// handshake with programmable wait states. It also owns the LL/SC
// reservation monitor, decides SC pass/fail and suppresses failed SC writes.
// Byte lanes assume BITS is a multiple of 8. Lanes above bit 31 are only
// written by full-word (byte_en == 0) writes.
module dmem_responder #(
    parameter int BITS        = 32,
    parameter int WORDS       = 256,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            req,
    output logic            ready,
    input  logic            we_,
    input  logic            ll,
    input  logic            sc,
    input  logic [BITS-1:0] addr,
    input  logic [BITS-1:0] wdata,
    input  logic [3:0]      byte_en,
    output logic            rvalid,
    output logic [BITS-1:0] rdata,
    output logic            sc_ok,
    output logic            err
);

    localparam int              IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BITS-1:0] BASE_V    = BITS'(BASE_ADDR);
    localparam logic [BITS-1:0] WORDS_V   = BITS'(WORDS);
    localparam logic [3:0]      WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            weN_q, weN_d;
    logic            ll_q, ll_d;
    logic            sc_q, sc_d;
    logic [BITS-1:0] addr_q, addr_d;
    logic [BITS-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            resvValid_q, resvValid_d;
    logic [BITS-1:0] resvAddr_q, resvAddr_d;

    logic [BITS-1:0] mem_q [WORDS];

    logic [BITS-1:0] idx;
    logic [IDX_W-1:0] memIdx;
    logic            inRange;
    logic            inResp;
    logic            isSc;
    logic            isLl;
    logic            resvHit;
    logic            wrEn;
    logic            fullWord;
    logic [BITS-1:0] laneMask;
    logic [BITS-1:0] rdWord;

    // Address decode and reservation match for the latched request.
    assign idx      = addr_q - BASE_V;
    assign inRange  = (idx < WORDS_V);
    assign memIdx   = idx[IDX_W-1:0];
    assign inResp   = (state_q == RESP);
    assign isSc     = ~weN_q & sc_q;
    assign isLl     = weN_q & ll_q;
    assign resvHit  = resvValid_q & (addr_q == resvAddr_q);
    assign wrEn     = inResp & inRange & ~weN_q & (~sc_q | resvHit);
    assign fullWord = (be_q == 4'b0000);
    assign rdWord   = mem_q[memIdx];

    // Expand byte_en into a bit mask; an all-zero byte_en means full word.
    for (genvar k = 0; k < BITS / 8; k++) begin : g_lane
        if (k < 4) begin : g_en
            assign laneMask[8*k +: 8] = {8{fullWord | be_q[k]}};
        end else begin : g_full
            assign laneMask[8*k +: 8] = {8{fullWord}};
        end
    end

    // Handshake FSM state, wait counter and latched request fields.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            weN_q   <= 1'b1;
            ll_q    <= 1'b0;
            sc_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            weN_q   <= weN_d;
            ll_q    <= ll_d;
            sc_q    <= sc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, respond once in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        weN_d   = weN_q;
        ll_d    = ll_q;
        sc_d    = sc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    weN_d   = we_;
                    ll_d    = ll;
                    sc_d    = sc;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = byte_en;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reservation registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            resvValid_q <= 1'b0;
            resvAddr_q  <= '0;
        end else begin
            resvValid_q <= resvValid_d;
            resvAddr_q  <= resvAddr_d;
        end
    end

    // Reservation update at response: SC always consumes, LL sets, a plain write to the reserved word kills.
    always_comb begin
        resvValid_d = resvValid_q;
        resvAddr_d  = resvAddr_q;
        if (inResp && inRange) begin
            if (isSc) begin
                resvValid_d = 1'b0;
            end else if (isLl) begin
                resvValid_d = 1'b1;
                resvAddr_d  = addr_q;
            end else if (!weN_q && resvHit) begin
                resvValid_d = 1'b0;
            end
        end
    end

    // Storage array, deliberately not reset; writes commit on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[memIdx] <= (mem_q[memIdx] & ~laneMask) | (wdata_q & laneMask);
        end
    end

    // Response outputs, all forced to zero outside RESP.
    always_comb begin
        rvalid = inResp;
        rdata  = '0;
        sc_ok  = 1'b0;
        err    = 1'b0;
        if (inResp) begin
            if (!inRange) begin
                err = 1'b1;
            end else if (isSc) begin
                sc_ok = resvHit;
                rdata = {{(BITS-1){1'b0}}, resvHit};
            end else if (weN_q) begin
                rdata = rdWord;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Testbench for dmem_responder: directed and random traffic driven into the
// handshake, with expected responses queued at issue time and compared by an
// independent monitor whenever rvalid is seen.
module tb_dmem_responder;

    localparam int BITS  = 32;
    localparam int WORDS = 256;
    localparam int BASE  = 16;
    localparam int WS    = 1;
    localparam int WIN   = 10;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        req = 1'b0;
    logic        we_ = 1'b1;
    logic        ll = 1'b0;
    logic        sc = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  byte_en = 4'd0;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        sc_ok;
    logic        err;

    dmem_responder #(
        .BITS(BITS),
        .WORDS(WORDS),
        .BASE_ADDR(BASE),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .req(req),
        .ready(ready),
        .we_(we_),
        .ll(ll),
        .sc(sc),
        .addr(addr),
        .wdata(wdata),
        .byte_en(byte_en),
        .rvalid(rvalid),
        .rdata(rdata),
        .sc_ok(sc_ok),
        .err(err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        scOk;
        logic        err;
        int          edgeNo;
        string       tag;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] refMem [WORDS];
    logic        refResvValid = 1'b0;
    logic [31:0] refResvAddr = 32'd0;
    int          cyc = 0;
    int          checkCount = 0;
    int          passCount = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        logic [31:0] m;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be == 4'b0000 || ((be >> k) & 4'b0001) != 4'b0000) begin
                m = 32'hFF << (8 * k);
                r = (r & ~m) | (wd & m);
            end
        end
        return r;
    endfunction

    // Reference model: applies one access to the model memory/reservation and returns the expected response.
    task automatic refModel(input logic weN, input logic llIn, input logic scIn,
                            input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                            output exp_t e);
        logic [31:0] off;
        logic        hit;
        e.rdata  = 32'd0;
        e.scOk   = 1'b0;
        e.err    = 1'b0;
        e.edgeNo = 0;
        e.tag    = "";
        off = a - 32'(BASE);
        if (off >= 32'(WORDS)) begin
            e.err = 1'b1;
            return;
        end
        hit = refResvValid && (a == refResvAddr);
        if (!weN && scIn) begin
            if (hit) begin
                refMem[off[7:0]] = mergeBytes(refMem[off[7:0]], wd, be);
                e.scOk  = 1'b1;
                e.rdata = 32'd1;
            end
            refResvValid = 1'b0;
        end else if (weN) begin
            e.rdata = refMem[off[7:0]];
            if (llIn) begin
                refResvValid = 1'b1;
                refResvAddr  = a;
            end
        end else begin
            refMem[off[7:0]] = mergeBytes(refMem[off[7:0]], wd, be);
            if (hit) refResvValid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic weN, input logic llIn, input logic scIn,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                                 input string tag, input bit holdReq);
        int   guard;
        int   lowCycles;
        exp_t e;
        @(negedge clk);
        we_ = weN; ll = llIn; sc = scIn; addr = a; wdata = wd; byte_en = be; req = 1'b1;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            checkOutput({tag, " accept timeout"}, 32'd0, 32'd1);
            req = 1'b0;
            return;
        end
        refModel(weN, llIn, scIn, a, wd, be, e);
        e.edgeNo = cyc + 1 + WS;
        e.tag    = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (holdReq) begin
            we_ = 1'b0; ll = 1'b0; sc = 1'b0; addr = 32'(BASE + 6); wdata = 32'hBAD0BAD0; byte_en = 4'd0;
        end else begin
            req = 1'b0;
        end
        lowCycles = 0;
        @(negedge clk);
        while (!ready && lowCycles < 50) begin
            lowCycles++;
            @(negedge clk);
        end
        req = 1'b0;
        checkOutput({tag, " ready-low cycles"}, 32'(lowCycles), 32'(WS + 1));
    endtask

    task automatic abortMidWrite(input logic [31:0] a, input logic [31:0] wd);
        int guard;
        @(negedge clk);
        we_ = 1'b0; ll = 1'b0; sc = 1'b0; addr = a; wdata = wd; byte_en = 4'd0; req = 1'b1;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checkOutput("abort in WAIT ready", 32'(ready), 32'd0);
        rst_ = 1'b0;
        #1 checkOutput("abort rvalid in reset", 32'(rvalid), 32'd0);
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        refResvValid = 1'b0;
        @(negedge clk);
        checkOutput("ready after abort reset", 32'(ready), 32'd1);
    endtask

    // Monitor: pops the scoreboard on every response and checks idle outputs otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected rvalid", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.tag, " rdata"}, rdata, e.rdata);
                checkOutput({e.tag, " sc_ok"}, 32'(sc_ok), 32'(e.scOk));
                checkOutput({e.tag, " err"}, 32'(err), 32'(e.err));
                checkOutput({e.tag, " rvalid edge"}, 32'(cyc), 32'(e.edgeNo));
                checkOutput({e.tag, " ready in RESP"}, 32'(ready), 32'd0);
            end
        end else if (rst_) begin
            checkOutput("idle sc_ok/err", {30'd0, sc_ok, err}, 32'd0);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        checkCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Main stimulus sequence.
    initial begin
        int          r;
        int          kind;
        logic [31:0] a;
        logic        bitA;
        logic [3:0]  be;

        repeat (2) @(negedge clk);
        checkOutput("reset rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset sc_ok", 32'(sc_ok), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        rst_ = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset", 32'(ready), 32'd1);

        for (int o = 0; o < WIN; o++)
            applyStimulus(1'b0, 1'b0, 1'b0, 32'(BASE + o), 32'h1000_0000 + 32'(o), 4'd0, "preload", 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'(BASE + 5), 32'hDEADBEEF, 4'd0, "write5", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 5), 32'd0, 4'd0, "read5", 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'(BASE + 7), 32'h11223344, 4'd0, "write7", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'(BASE + 7), 32'hAABBCCDD, 4'b0101, "lanes7", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 7), 32'd0, 4'd0, "read7", 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'(BASE + 9), 32'd0, 4'd0, "ll9", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'(BASE + 9), 32'h55, 4'd0, "sc9 pass", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'(BASE + 9), 32'h66, 4'd0, "sc9 fail", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 9), 32'd0, 4'd0, "read9", 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'(BASE + 3), 32'd0, 4'd0, "ll3", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'(BASE + 3), 32'h1, 4'd0, "kill3", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'(BASE + 3), 32'h2, 4'd0, "sc3 killed", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 3), 32'd0, 4'd0, "read3", 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'(BASE + 3), 32'd0, 4'd0, "ll3 again", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'(BASE + 4), 32'h4, 4'd0, "write4", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'(BASE + 3), 32'h2, 4'd0, "sc3 survives", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 3), 32'd0, 4'd0, "read3 again", 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE - 1), 32'd0, 4'd0, "read below base", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'(BASE + WORDS), 32'hFFFFFFFF, 4'd0, "write past end", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE), 32'd0, 4'd0, "read0", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 1), 32'd0, 4'd0, "read1 req held", 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 6), 32'd0, 4'd0, "read6", 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'(BASE + 2), 32'd0, 4'd0, "ll2", 1'b0);
        abortMidWrite(32'(BASE + 2), 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 2), 32'd0, 4'd0, "read2 after abort", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'(BASE + 2), 32'h77, 4'd0, "sc2 after abort", 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'(BASE + 2), 32'd0, 4'd0, "read2 final", 1'b0);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 17) a = 32'(BASE) + 32'($urandom_range(0, WIN - 1));
            else if (r == 17) a = 32'(BASE - 1);
            else if (r == 18) a = 32'(BASE + WORDS);
            else a = $urandom;
            kind = int'($urandom_range(0, 9));
            bitA = 1'($urandom_range(0, 1));
            be   = 4'($urandom_range(0, 15));
            if (kind <= 2) begin
                applyStimulus(1'b1, 1'b0, bitA, a, $urandom, be, "rnd read", 1'b0);
            end else if (kind <= 4) begin
                applyStimulus(1'b1, 1'b1, bitA, a, $urandom, be, "rnd ll", 1'b0);
            end else if (kind <= 7) begin
                applyStimulus(1'b0, bitA, 1'b0, a, $urandom, be, "rnd write", 1'b0);
            end else begin
                if (refResvValid && bitA) a = refResvAddr;
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, a, $urandom, be, "rnd sc", 1'b0);
            end
        end

        repeat (10) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
